// File: rtl/alu_ops_pkg.sv
// Shared ALU op codes, issue FSM encoding and op decode helpers used by the
// decode/control logic, the issue arbiter and the ALU itself.
package alu_ops_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    // Unknown op codes are issued as ADD so the ALU never sees an undefined op.
    function automatic logic [OP_W-1:0] sanitize_op(input logic [OP_W-1:0] op);
        logic [OP_W-1:0] res;
        if (op > OP_OR) begin
            res = OP_ADD;
        end else begin
            res = op;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the port that did not win last time has
// priority on a tie. Reset favours port 0 for the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant_r;

    // One-hot grant from the request pair and the last winner.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (last_grant_r) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner whenever a grant is actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (advance) begin
            last_grant_r <= gnt[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between the execute stage (port 0) and the address/branch
// unit (port 1): arbitrates, holds op/operands for the op latency, returns tagged results.
module alu_issue_arbiter
    import alu_ops_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              busy
);

    logic [0:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              owner_r;
    logic [1:0]        arb_req_s;
    logic [1:0]        gnt_s;
    logic              advance_s;
    logic [OP_W-1:0]   sel_op_s;
    logic [DATA_W-1:0] sel_a_s;
    logic [DATA_W-1:0] sel_b_s;
    logic [CNT_W-1:0]  cnt_load_s;

    // Requests only reach the arbiter while the ALU is free.
    always_comb begin
        if (state_r == IDLE) begin
            arb_req_s = {req1_valid, req0_valid};
        end else begin
            arb_req_s = 2'b00;
        end
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req_s),
        .advance (advance_s),
        .gnt     (gnt_s)
    );

    assign advance_s  = |gnt_s;
    assign req0_ready = gnt_s[0];
    assign req1_ready = gnt_s[1];
    assign busy       = state_r;

    // Select the granted request and derive its remaining-cycle count.
    always_comb begin
        if (gnt_s[1]) begin
            sel_op_s = sanitize_op(req1_op);
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = sanitize_op(req0_op);
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
        if (sel_op_s == OP_MUL) begin
            cnt_load_s = CNT_W'(MUL_LAT - 1);
        end else begin
            cnt_load_s = {CNT_W{1'b0}};
        end
    end

    // Issue FSM: latch on accept, hold through EXEC, capture the result on the last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            owner_r     <= 1'b0;
            alu_op      <= {OP_W{1'b0}};
            alu_a       <= {DATA_W{1'b0}};
            alu_b       <= {DATA_W{1'b0}};
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= {DATA_W{1'b0}};
        end else begin
            resp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (advance_s) begin
                        alu_op  <= sel_op_s;
                        alu_a   <= sel_a_s;
                        alu_b   <= sel_b_s;
                        owner_r <= gnt_s[1];
                        cnt_r   <= cnt_load_s;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        resp_valid  <= 1'b1;
                        resp_id     <= owner_r;
                        resp_result <= alu_result;
                        state_r     <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: directed scenarios plus a
// randomized two-requester run against a transaction-level reference model.
module tb_alu_issue_arbiter;

    localparam int DW      = 32;
    localparam int MUL_LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [3:0]    req0_op, req1_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          resp_valid, resp_id, busy;
    logic [DW-1:0] resp_result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.DATA_W(DW), .MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .busy(busy)
    );

    // Behavioural ALU; undefined op codes give a poison value
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a * alu_b;
            4'd3:    alu_result = alu_a & alu_b;
            4'd4:    alu_result = alu_a | alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        if (op == 4'd1) return a - b;
        else if (op == 4'd2) return a * b;
        else if (op == 4'd3) return a & b;
        else if (op == 4'd4) return a | b;
        else return a + b;
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = '0; req1_b = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if ({alu_op, alu_a, alu_b} !== '0) begin
            n_err++; $display("FAIL reset_alu got op=%0d a=%0h b=%0h exp 0", alu_op, alu_a, alu_b);
        end
        n_cmp++;
        if ({resp_valid, resp_id, resp_result, busy} !== '0) begin
            n_err++; $display("FAIL reset_resp got v=%b id=%b r=%0h busy=%b exp 0", resp_valid, resp_id, resp_result, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_add;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd3;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL add_ready got %b%b exp 10", req0_ready, req1_ready);
        end
        cyc();
        req0_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || resp_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd3) begin
            n_err++; $display("FAIL add_exec got busy=%b v=%b a=%0d b=%0d", busy, resp_valid, alu_a, alu_b);
        end
        cyc();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 32'd8 || busy !== 1'b0) begin
            n_err++; $display("FAIL add_resp got v=%b id=%b r=%0d busy=%b exp 1 0 8 0", resp_valid, resp_id, resp_result, busy);
        end
        cyc();
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++; $display("FAIL add_pulse got v=%b exp 0", resp_valid);
        end
    endtask

    task automatic test_tie;
        bit            g;
        logic [DW-1:0] r;
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 32'd9;    req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'hF0;   req1_b = 32'h0F;
        for (int j = 0; j < 16; j++) begin
            #1;
            if (j % 2 == 0) begin
                g = ((j / 2) % 2) == 1;
                n_cmp++;
                if (req0_ready !== !g || req1_ready !== g) begin
                    n_err++; $display("FAIL tie_grant j=%0d got %b%b exp port %0d", j, req0_ready, req1_ready, g);
                end
            end else begin
                n_cmp++;
                if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                    n_err++; $display("FAIL tie_busy j=%0d got r=%b%b busy=%b", j, req0_ready, req1_ready, busy);
                end
            end
            if (j >= 2 && j % 2 == 0) begin
                g = (((j / 2) - 1) % 2) == 1;
                r = g ? 32'hFF : 32'd5;
                n_cmp++;
                if (resp_valid !== 1'b1 || resp_id !== g || resp_result !== r) begin
                    n_err++; $display("FAIL tie_resp j=%0d got v=%b id=%b r=%0h exp 1 %0d %0h", j, resp_valid, resp_id, resp_result, g, r);
                end
            end else begin
                n_cmp++;
                if (resp_valid !== 1'b0) begin
                    n_err++; $display("FAIL tie_noresp j=%0d got v=%b", j, resp_valid);
                end
            end
            cyc();
        end
        clear_inputs();
        cyc();
        cyc();
    endtask

    task automatic test_mul;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'd6; req1_b = 32'd7;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_err++; $display("FAIL mul_ready got %b%b exp 01", req0_ready, req1_ready);
        end
        cyc();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
        for (int i = 1; i <= MUL_LAT; i++) begin
            #1;
            n_cmp++;
            if (busy !== 1'b1 || alu_op !== 4'd2 || alu_a !== 32'd6 || alu_b !== 32'd7
                || req0_ready !== 1'b0 || resp_valid !== 1'b0) begin
                n_err++; $display("FAIL mul_hold i=%0d got busy=%b op=%0d a=%0d b=%0d rdy0=%b v=%b",
                                  i, busy, alu_op, alu_a, alu_b, req0_ready, resp_valid);
            end
            cyc();
        end
        #1;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_result !== 32'd42 || req0_ready !== 1'b1) begin
            n_err++; $display("FAIL mul_resp got v=%b id=%b r=%0d rdy0=%b exp 1 1 42 1", resp_valid, resp_id, resp_result, req0_ready);
        end
        cyc();
        req0_valid = 1'b0;
        cyc();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 32'd2) begin
            n_err++; $display("FAIL mul_wait_resp got v=%b id=%b r=%0d exp 1 0 2", resp_valid, resp_id, resp_result);
        end
        cyc();
    endtask

    task automatic test_invalid_op;
        req0_valid = 1'b1; req0_op = 4'hA; req0_a = 32'd1; req0_b = 32'd2;
        cyc();
        req0_valid = 1'b0;
        n_cmp++;
        if (alu_op !== 4'd0 || busy !== 1'b1) begin
            n_err++; $display("FAIL inv_op got op=%0d busy=%b exp 0 1", alu_op, busy);
        end
        cyc();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_result !== 32'd3) begin
            n_err++; $display("FAIL inv_resp got v=%b r=%0d exp 1 3", resp_valid, resp_result);
        end
        cyc();
    endtask

    task automatic test_reset_mid_mul;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'd3; req1_b = 32'd3;
        cyc();
        clear_inputs();
        cyc();
        rst = 1'b1;
        cyc();
        n_cmp++;
        if ({alu_op, alu_a, alu_b, resp_valid, resp_id, resp_result, busy} !== '0) begin
            n_err++; $display("FAIL rstmid_vals got op=%0d a=%0d b=%0d v=%b id=%b r=%0d busy=%b",
                              alu_op, alu_a, alu_b, resp_valid, resp_id, resp_result, busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_cmp++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL rstmid_drop i=%0d got v=%b busy=%b exp 0 0", i, resp_valid, busy);
            end
        end
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd2; req0_b = 32'd2;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_ready got %b exp 1", req0_ready);
        end
        cyc();
        clear_inputs();
        cyc();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 32'd4) begin
            n_err++; $display("FAIL rstmid_resp got v=%b id=%b r=%0d exp 1 0 4", resp_valid, resp_id, resp_result);
        end
        cyc();
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] e;
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd0;
        for (int j = 0; j < 12; j++) begin
            if (j % 2 == 0) begin
                req0_a = $urandom; req0_b = $urandom;
                exp_q.push_back(req0_a + req0_b);
            end
            #1;
            n_cmp++;
            if (req0_ready !== (j % 2 == 0)) begin
                n_err++; $display("FAIL b2b_ready j=%0d got %b", j, req0_ready);
            end
            if (j >= 2 && j % 2 == 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (resp_valid !== 1'b1 || resp_result !== e) begin
                    n_err++; $display("FAIL b2b_resp j=%0d got v=%b r=%0h exp 1 %0h", j, resp_valid, resp_result, e);
                end
            end else begin
                n_cmp++;
                if (resp_valid !== 1'b0) begin
                    n_err++; $display("FAIL b2b_noresp j=%0d got v=%b", j, resp_valid);
                end
            end
            cyc();
        end
        clear_inputs();
        cyc();
        cyc();
    endtask

    function automatic logic [3:0] rand_op();
        if ($urandom_range(15, 0) < 12) return 4'($urandom_range(4, 0));
        else return 4'($urandom_range(15, 5));
    endfunction

    // Transaction model: an accepted op occupies the ALU until its response cycle
    task automatic test_random;
        int            due, last, g;
        bit            idle, acc_id;
        logic          v0, v1;
        logic [3:0]    op0, op1, eop;
        logic [DW-1:0] a0, b0, a1, b1, ea, eb, eres;
        do_reset();
        last = 1; due = -1; acc_id = 1'b0; eres = '0;
        eop = 4'd0; ea = '0; eb = '0;
        v0 = 1'b0; v1 = 1'b0;
        op0 = 4'd0; op1 = 4'd0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        for (int c = 0; c < 600; c++) begin
            if (!v0 && $urandom_range(1, 0) == 1) begin
                v0 = 1'b1; op0 = rand_op(); a0 = $urandom; b0 = $urandom;
            end else if (v0 && $urandom_range(15, 0) == 0) begin
                v0 = 1'b0;
            end
            if (!v1 && $urandom_range(1, 0) == 1) begin
                v1 = 1'b1; op1 = rand_op(); a1 = $urandom; b1 = $urandom;
            end else if (v1 && $urandom_range(15, 0) == 0) begin
                v1 = 1'b0;
            end
            req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
            req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
            #1;
            idle = (c >= due);
            g = -1;
            if (idle && (v0 || v1)) begin
                if (v0 && v1) g = (last == 1) ? 0 : 1;
                else g = v0 ? 0 : 1;
            end
            n_cmp++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                n_err++; $display("FAIL rnd_ready c=%0d got %b%b exp grant %0d", c, req0_ready, req1_ready, g);
            end
            n_cmp++;
            if (busy !== !idle) begin
                n_err++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy, !idle);
            end
            n_cmp++;
            if (alu_op !== eop || alu_a !== ea || alu_b !== eb) begin
                n_err++; $display("FAIL rnd_alu c=%0d got %0d %0h %0h exp %0d %0h %0h", c, alu_op, alu_a, alu_b, eop, ea, eb);
            end
            n_cmp++;
            if (resp_valid !== (c == due)) begin
                n_err++; $display("FAIL rnd_rvalid c=%0d got %b exp %b", c, resp_valid, c == due);
            end else if (c == due) begin
                n_cmp++;
                if (resp_id !== acc_id || resp_result !== eres) begin
                    n_err++; $display("FAIL rnd_resp c=%0d got id=%b r=%0h exp id=%b r=%0h", c, resp_id, resp_result, acc_id, eres);
                end
            end
            if (g >= 0) begin
                eop = (g == 0) ? op0 : op1;
                if (eop > 4'd4) eop = 4'd0;
                ea = (g == 0) ? a0 : a1;
                eb = (g == 0) ? b0 : b1;
                eres = ref_alu(eop, ea, eb);
                acc_id = (g == 1);
                due = c + 1 + ((eop == 4'd2) ? MUL_LAT : 1);
                last = g;
                if (g == 0) v0 = 1'b0;
                else v1 = 1'b0;
            end
            cyc();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_single_add();
        test_tie();
        test_mul();
        test_invalid_op();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
